// File: rtl/uart_host_bus_master.sv
// Host-side initiator for the UART 8-bit register port: runs timed strobe
// accesses for host commands and fetches the interrupt ID when irq_n_i falls.
module uart_host_bus_master #(
  parameter int          STROBE_CYCLES  = 2,
  parameter int          RECOVER_CYCLES = 2,
  parameter logic [2:0]  INT_ID_ADDR    = 3'd4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_write_i,
  input  logic [2:0] cmd_addr_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       irq_valid_o,
  output logic [2:0] irq_id_o,
  output logic       busy_o,
  output logic [2:0] address_o,
  output logic       read_o,
  output logic       write_o,
  output logic [7:0] data_o,
  output logic       data_oe_o,
  input  logic [7:0] data_i,
  input  logic       irq_n_i
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

  localparam logic [3:0] STROBE_LAST  = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lat_write_q, lat_irq_q;
  logic [2:0] lat_addr_q;
  logic [7:0] lat_wdata_q;
  logic       irq_sync1_q, irq_sync2_q, irq_prev_q, irq_fall_q, irq_pending_q;
  logic [7:0] rsp_rdata_q;
  logic [2:0] irq_id_q;
  logic       launch_irq, launch_cmd, last_strobe, last_recover;

  // Handshake: a command transfers on a rising edge where cmd_valid_i and
  // cmd_ready_o are both high; ready never depends on valid, and a pending
  // interrupt always wins over a waiting command.
  assign cmd_ready_o  = (state_q == IDLE) & ~irq_pending_q & ~rst_i;
  assign launch_irq   = (state_q == IDLE) & irq_pending_q;
  assign launch_cmd   = cmd_valid_i & cmd_ready_o;
  assign last_strobe  = (state_q == STROBE) && (cnt_q == STROBE_LAST);
  assign last_recover = (state_q == RECOVER) && (cnt_q == RECOVER_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      lat_write_q   <= 1'b0;
      lat_irq_q     <= 1'b0;
      lat_addr_q    <= '0;
      lat_wdata_q   <= '0;
      irq_sync1_q   <= 1'b1;
      irq_sync2_q   <= 1'b1;
      irq_prev_q    <= 1'b1;
      irq_fall_q    <= 1'b0;
      irq_pending_q <= 1'b0;
      rsp_rdata_q   <= '0;
      irq_id_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      irq_sync1_q <= irq_n_i;
      irq_sync2_q <= irq_sync1_q;
      irq_prev_q  <= irq_sync2_q;
      // Registered edge pulse: a held-low line cannot re-arm the service.
      irq_fall_q  <= irq_prev_q & ~irq_sync2_q;
      if (irq_fall_q) begin
        irq_pending_q <= 1'b1;
      end else if (launch_irq) begin
        irq_pending_q <= 1'b0;
      end
      if (launch_irq) begin
        lat_write_q <= 1'b0;
        lat_irq_q   <= 1'b1;
        lat_addr_q  <= INT_ID_ADDR;
      end else if (launch_cmd) begin
        lat_write_q <= cmd_write_i;
        lat_irq_q   <= 1'b0;
        lat_addr_q  <= cmd_addr_i;
        lat_wdata_q <= cmd_wdata_i;
      end
      if (last_strobe && !lat_write_q) begin
        if (lat_irq_q) begin
          irq_id_q <= data_i[2:0];
        end else begin
          rsp_rdata_q <= data_i;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (launch_irq || launch_cmd) state_d = SETUP;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: begin
        if (last_strobe) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RECOVER: begin
        if (last_recover) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    address_o   = lat_addr_q;
    data_o      = lat_wdata_q;
    rsp_rdata_o = rsp_rdata_q;
    irq_id_o    = irq_id_q;
    busy_o      = (state_q != IDLE);
    read_o      = 1'b0;
    write_o     = 1'b0;
    data_oe_o   = 1'b0;
    rsp_valid_o = 1'b0;
    irq_valid_o = 1'b0;
    case (state_q)
      SETUP: data_oe_o = lat_write_q;
      STROBE: begin
        data_oe_o = lat_write_q;
        write_o   = lat_write_q;
        read_o    = ~lat_write_q;
      end
      RECOVER: begin
        rsp_valid_o = (cnt_q == 4'd0) & ~lat_irq_q;
        irq_valid_o = (cnt_q == 4'd0) & lat_irq_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_host_bus_master.sv
// Bench for uart_host_bus_master: default-timing instance plus a
// STROBE_CYCLES=3 / RECOVER_CYCLES=1 instance for back-to-back traffic.
module tb_uart_host_bus_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd_ready, cmd_write, rsp_valid, irq_valid, busy;
  logic       read_s, write_s, data_oe, irq_n;
  logic [2:0] cmd_addr, irq_id, address;
  logic [7:0] cmd_wdata, rsp_rdata, data_out, data_in;

  logic       cmd_valid_b, cmd_ready_b, cmd_write_b, rsp_valid_b, irq_valid_b, busy_b;
  logic       read_b, write_b, data_oe_b, irq_n_b;
  logic [2:0] cmd_addr_b, irq_id_b, address_b;
  logic [7:0] cmd_wdata_b, rsp_rdata_b, data_out_b, data_in_b;

  uart_host_bus_master u_dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .irq_valid_o(irq_valid), .irq_id_o(irq_id), .busy_o(busy),
    .address_o(address), .read_o(read_s), .write_o(write_s),
    .data_o(data_out), .data_oe_o(data_oe), .data_i(data_in), .irq_n_i(irq_n)
  );

  uart_host_bus_master #(.STROBE_CYCLES(3), .RECOVER_CYCLES(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_b), .cmd_ready_o(cmd_ready_b), .cmd_write_i(cmd_write_b),
    .cmd_addr_i(cmd_addr_b), .cmd_wdata_i(cmd_wdata_b),
    .rsp_valid_o(rsp_valid_b), .rsp_rdata_o(rsp_rdata_b),
    .irq_valid_o(irq_valid_b), .irq_id_o(irq_id_b), .busy_o(busy_b),
    .address_o(address_b), .read_o(read_b), .write_o(write_b),
    .data_o(data_out_b), .data_oe_o(data_oe_b), .data_i(data_in_b), .irq_n_i(irq_n_b)
  );

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  logic [2:0] irq_q[$];
  logic [7:0] model_rdata;
  logic [7:0] e8;
  logic [2:0] e3;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({cmd_ready, busy, read_s, write_s, data_oe, rsp_valid, irq_valid} !== 7'b0)
      $display("FAIL reset_ctrl act=%b exp=0", {cmd_ready, busy, read_s, write_s, data_oe, rsp_valid, irq_valid});
    else passes++;
    checks++;
    if ({address, data_out, rsp_rdata, irq_id} !== 22'b0)
      $display("FAIL reset_data act=%h exp=0", {address, data_out, rsp_rdata, irq_id});
    else passes++;
    checks++;
    if ({cmd_ready_b, busy_b} !== 2'b00)
      $display("FAIL reset_b act=%b exp=00", {cmd_ready_b, busy_b});
    else passes++;
    rst = 1'b0;
    model_rdata = 8'h00;
    tick();
    checks++;
    if ({cmd_ready, busy} !== 2'b10) $display("FAIL reset_release act=%b exp=10", {cmd_ready, busy});
    else passes++;
  endtask

  // Single host access from IDLE; data_i carries rdv only in the last strobe cycle.
  task automatic test_access(input bit wr, input logic [2:0] addr, input logic [7:0] wdata,
                             input logic [7:0] rdv);
    logic [6:0] act, exp;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    data_in   = ~rdv;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL access_ready0 act=%b exp=1", cmd_ready);
    else passes++;
    if (wr) exp_q.push_back(model_rdata);
    else begin
      exp_q.push_back(rdv);
      model_rdata = rdv;
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) cmd_valid = 1'b0;
      data_in = (c == 3) ? rdv : ~rdv;
      exp = {wr && (c == 2 || c == 3), !wr && (c == 2 || c == 3), wr && c <= 3,
             c == 4, c == 6, 1'b0, c <= 5};
      act = {write_s, read_s, data_oe, rsp_valid, cmd_ready, irq_valid, busy};
      checks++;
      if (act !== exp) $display("FAIL access_vec wr=%0d c=%0d act=%b exp=%b", wr, c, act, exp);
      else passes++;
      if (c <= 5) begin
        checks++;
        if (address !== addr) $display("FAIL access_addr c=%0d act=%0d exp=%0d", c, address, addr);
        else passes++;
      end
      if (wr && c <= 3) begin
        checks++;
        if (data_out !== wdata) $display("FAIL access_wdata c=%0d act=%h exp=%h", c, data_out, wdata);
        else passes++;
      end
      if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL access_rsp unexpected act=%h exp=none", rsp_rdata);
        else begin
          e8 = exp_q.pop_front();
          if (rsp_rdata !== e8) $display("FAIL access_rsp act=%h exp=%h", rsp_rdata, e8);
          else passes++;
        end
      end
    end
  endtask

  task automatic test_irq_idle;
    logic [4:0] act, exp;
    int busy_seen;
    data_in = 8'h06;
    irq_q.push_back(3'd6);
    irq_n = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      tick();
      exp = {c >= 4 && c <= 8, c == 5 || c == 6, c == 7, 1'b0, c <= 2 || c >= 9};
      act = {busy, read_s, irq_valid, rsp_valid, cmd_ready};
      checks++;
      if (act !== exp) $display("FAIL irq_idle_vec c=%0d act=%b exp=%b", c, act, exp);
      else passes++;
      if (busy) begin
        checks++;
        if ({address, data_oe} !== {3'd4, 1'b0})
          $display("FAIL irq_idle_bus c=%0d act=%0d/%b exp=4/0", c, address, data_oe);
        else passes++;
      end
      if (irq_valid) begin
        checks++;
        if (irq_q.size() == 0) $display("FAIL irq_idle_id unexpected act=%0d exp=none", irq_id);
        else begin
          e3 = irq_q.pop_front();
          if (irq_id !== e3) $display("FAIL irq_idle_id act=%0d exp=%0d", irq_id, e3);
          else passes++;
        end
      end
    end
    busy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy) busy_seen++;
    end
    irq_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (busy) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) $display("FAIL irq_no_retrigger act=%0d busy cycles exp=0", busy_seen);
    else passes++;
  endtask

  // Fall lands during a write; the interrupt read must run before the held command.
  task automatic test_irq_during_write;
    logic [4:0] act, exp;
    data_in   = 8'h03;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 3'd1;
    cmd_wdata = 8'h5A;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL irqw_ready0 act=%b exp=1", cmd_ready);
    else passes++;
    exp_q.push_back(model_rdata);
    irq_q.push_back(3'd3);
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 1) irq_n = 1'b0;
      if (c == 13) cmd_valid = 1'b0;
      exp = {c == 2 || c == 3 || c == 14 || c == 15, c == 8 || c == 9,
             c == 4 || c == 16, c == 10, c == 12 || c == 18};
      act = {write_s, read_s, rsp_valid, irq_valid, cmd_ready};
      checks++;
      if (act !== exp) $display("FAIL irqw_vec c=%0d act=%b exp=%b", c, act, exp);
      else passes++;
      if (read_s || write_s) begin
        checks++;
        if (address !== (read_s ? 3'd4 : 3'd1))
          $display("FAIL irqw_addr c=%0d act=%0d exp=%0d", c, address, read_s ? 3'd4 : 3'd1);
        else passes++;
      end
      if (c == 12 && cmd_valid && cmd_ready) exp_q.push_back(model_rdata);
      if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL irqw_rsp unexpected act=%h exp=none", rsp_rdata);
        else begin
          e8 = exp_q.pop_front();
          if (rsp_rdata !== e8) $display("FAIL irqw_rsp act=%h exp=%h", rsp_rdata, e8);
          else passes++;
        end
      end
      if (irq_valid) begin
        checks++;
        if (irq_q.size() == 0) $display("FAIL irqw_id unexpected act=%0d exp=none", irq_id);
        else begin
          e3 = irq_q.pop_front();
          if (irq_id !== e3) $display("FAIL irqw_id act=%0d exp=%0d", irq_id, e3);
          else passes++;
        end
      end
    end
    irq_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
  endtask

  // Gap between strobes is RECOVER + IDLE + SETUP, so the period is S + R + 2 = 6.
  task automatic test_back_to_back;
    logic [2:0] act, exp;
    cmd_valid_b = 1'b1;
    cmd_write_b = 1'b0;
    cmd_addr_b  = 3'd5;
    data_in_b   = 8'($urandom_range(0, 255));
    checks++;
    if (cmd_ready_b !== 1'b1) $display("FAIL b2b_ready0 act=%b exp=1", cmd_ready_b);
    else passes++;
    for (int c = 1; c <= 24; c++) begin
      tick();
      exp = {(c % 6) >= 2 && (c % 6) <= 4, (c % 6) == 5, 1'b0};
      act = {read_b, rsp_valid_b, data_oe_b};
      checks++;
      if (act !== exp) $display("FAIL b2b_vec c=%0d act=%b exp=%b", c, act, exp);
      else passes++;
      if (rsp_valid_b) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_rsp unexpected act=%h exp=none", rsp_rdata_b);
        else begin
          e8 = exp_q.pop_front();
          if (rsp_rdata_b !== e8) $display("FAIL b2b_rsp c=%0d act=%h exp=%h", c, rsp_rdata_b, e8);
          else passes++;
        end
      end
      if (c == 24) cmd_valid_b = 1'b0;
      data_in_b = 8'($urandom_range(0, 255));
      if ((c % 6) == 4) exp_q.push_back(data_in_b);
    end
    tick();
    checks++;
    if (busy_b !== 1'b0) $display("FAIL b2b_idle act=%b exp=0", busy_b);
    else passes++;
  endtask

  task automatic test_reset_mid;
    int stray;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 3'd3;
    data_in   = 8'h77;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL rstmid_ready0 act=%b exp=1", cmd_ready);
    else passes++;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (read_s !== 1'b1) $display("FAIL rstmid_strobe act=%b exp=1", read_s);
    else passes++;
    rst = 1'b1;
    tick();
    checks++;
    if ({read_s, data_oe, busy, rsp_valid, cmd_ready} !== 5'b0)
      $display("FAIL rstmid_drop act=%b exp=00000", {read_s, data_oe, busy, rsp_valid, cmd_ready});
    else passes++;
    rst = 1'b0;
    model_rdata = 8'h00;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid || irq_valid || busy) stray++;
    end
    checks++;
    if (stray != 0) $display("FAIL rstmid_quiet act=%0d active cycles exp=0", stray);
    else passes++;
    checks++;
    if (rsp_rdata !== 8'h00) $display("FAIL rstmid_rdata act=%h exp=00", rsp_rdata);
    else passes++;
    test_access(1'b0, 3'd6, 8'h00, 8'h81);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    data_in = '0; irq_n = 1'b1;
    cmd_valid_b = 1'b0; cmd_write_b = 1'b0; cmd_addr_b = '0; cmd_wdata_b = '0;
    data_in_b = '0; irq_n_b = 1'b1;
    model_rdata = 8'h00;
    test_reset();
    test_access(1'b1, 3'd2, 8'hA5, 8'h00);
    test_access(1'b0, 3'd5, 8'h00, 8'h3C);
    test_access(1'b1, 3'd7, 8'h0F, 8'h00);
    test_irq_idle();
    test_irq_during_write();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || irq_q.size() != 0)
      $display("FAIL drain act=%0d/%0d left exp=0/0", exp_q.size(), irq_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
